// File: rtl/mdu_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// master drives the operation request; slave returns busy/done and the HI/LO registers.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers and fixed per-class latency.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (op codes 6-9); otherwise they are no-ops.
module mdu #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd0;
  localparam logic [3:0] OpMultu = 4'd1;
  localparam logic [3:0] OpDiv   = 4'd2;
  localparam logic [3:0] OpDivu  = 4'd3;
  localparam logic [3:0] OpMthi  = 4'd4;
  localparam logic [3:0] OpMtlo  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd6;
  localparam logic [3:0] OpMaddu = 4'd7;
  localparam logic [3:0] OpMsub  = 4'd8;
  localparam logic [3:0] OpMsubu = 4'd9;
`endif

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  // ---------------------------------------------------------------------------
  // Op classification
  // ---------------------------------------------------------------------------
  function automatic logic is_mul_class(input logic [3:0] o);
    logic r;
    case (o)
      OpMult, OpMultu: r = 1'b1;
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu, OpMsub, OpMsubu: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_class(input logic [3:0] o);
    return (o == OpDiv) || (o == OpDivu);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] o);
    logic r;
    case (o)
      OpMult, OpDiv: r = 1'b1;
`ifdef MDU_MADD_EN
      OpMadd, OpMsub: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // ---------------------------------------------------------------------------
  // Datapath on the latched operands
  // ---------------------------------------------------------------------------
  logic               sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  // Sign- or zero-extending to 2*WIDTH lets one unsigned multiplier serve both flavours.
  always_comb begin
    sgn   = is_signed_op(op_q);
    a_ext = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    b_ext = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    prod  = a_ext * b_ext;
  end

  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] abs_a, abs_b, divisor, uquo, urem, quo, rem;

  // Magnitude divide then fix signs; the most-negative / -1 case falls out as 0x80..0 / 0.
  always_comb begin
    a_neg    = sgn & a_q[WIDTH-1];
    b_neg    = sgn & b_q[WIDTH-1];
    abs_a    = a_neg ? -a_q : a_q;
    abs_b    = b_neg ? -b_q : b_q;
    div_zero = (b_q == '0);
    divisor  = div_zero ? WIDTH'(1) : abs_b;
    uquo     = abs_a / divisor;
    urem     = abs_a % divisor;
    quo      = (a_neg ^ b_neg) ? -uquo : uquo;
    rem      = a_neg ? -urem : urem;
  end

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    if ((op_q == OpMsub) || (op_q == OpMsubu)) begin
      acc_next = {hi_q, lo_q} - prod;
    end else begin
      acc_next = {hi_q, lo_q} + prod;
    end
  end
`endif

  logic             res_we;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    res_we = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OpMult, OpMultu: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = prod;
      end
      OpDiv, OpDivu: begin
        // Divide by zero still completes with full latency but leaves HI/LO alone.
        res_we = ~div_zero;
        res_hi = rem;
        res_lo = quo;
      end
`ifdef MDU_MADD_EN
      OpMadd, OpMaddu, OpMsub, OpMsubu: begin
        res_we           = 1'b1;
        {res_hi, res_lo} = acc_next;
      end
`endif
      default: res_we = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (is_mul_class(bus.op) || is_div_class(bus.op)) begin
            op_d    = bus.op;
            a_d     = bus.a;
            b_d     = bus.b;
            cnt_d   = is_div_class(bus.op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            state_d = StBusy;
          end else if (bus.op == OpMthi) begin
            hi_d = bus.a;
          end else if (bus.op == OpMtlo) begin
            lo_d = bus.a;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == StBusy);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed literal cases plus random traffic against a
// cycle-level behavioural model (completion scheduled by edge number, results by plain arithmetic).
module tb_mdu;

  localparam int unsigned NMul = 5;
  localparam int unsigned NDiv = 10;

  logic clk;
  logic reset;

  mdu_if #(.WIDTH(32)) bus ();

  mdu #(
    .WIDTH      (32),
    .MULT_CYCLES(NMul),
    .DIV_CYCLES (NDiv)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_op;
  bit          m_pend, m_done, m_valid;
  int unsigned cyc, m_end;

  task automatic model_finish();
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    ua = {32'b0, m_a};
    ub = {32'b0, m_b};
    case (m_op)
      4'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
      4'd1: begin p = ua * ub; {m_hi, m_lo} = p; end
      4'd2: if (m_b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4'd3: if (m_b != 0) begin
        m_lo = m_a / m_b;
        m_hi = m_a % m_b;
      end
`ifdef MDU_MADD_EN
      4'd6: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; end
      4'd7: begin p = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} + p; end
      4'd8: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} - p; end
      4'd9: begin p = ua * ub; {m_hi, m_lo} = {m_hi, m_lo} - p; end
`endif
      default: ;
    endcase
  endtask

  function automatic int unsigned op_latency(input logic [3:0] o);
    if (o == 4'd0 || o == 4'd1) return NMul;
    if (o == 4'd2 || o == 4'd3) return NDiv;
`ifdef MDU_MADD_EN
    if (o >= 4'd6 && o <= 4'd9) return NMul;
`endif
    return 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_hi    = '0;
      m_lo    = '0;
      m_pend  = 0;
      m_done  = 0;
      m_valid = 1;
    end else begin
      m_done = 0;
      if (m_pend) begin
        if (cyc == m_end) begin
          model_finish();
          m_pend = 0;
          m_done = 1;
        end
      end else if (bus.start) begin
        if (op_latency(bus.op) != 0) begin
          m_op   = bus.op;
          m_a    = bus.a;
          m_b    = bus.b;
          m_pend = 1;
          m_end  = cyc + op_latency(bus.op);
        end else if (bus.op == 4'd4) begin
          m_hi = bus.a;
        end else if (bus.op == 4'd5) begin
          m_lo = bus.a;
        end
      end
    end
    #1;
    if (m_valid) begin
      chk("model busy", bus.busy, m_pend);
      chk("model done", bus.done, m_done);
      chk("model hi", bus.hi, m_hi);
      chk("model lo", bus.lo, m_lo);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n_exp, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    issue(o, x, y);
    wait_idle(n);
    chk({nm, " busy cycles"}, n, n_exp);
    chk({nm, " done"}, bus.done, 1'b1);
    chk({nm, " hi"}, bus.hi, ehi);
    chk({nm, " lo"}, bus.lo, elo);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_done;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    m_valid     = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = '0;
    bus.a       = '0;
    bus.b       = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset hi", bus.hi, 32'h0);
    chk("reset lo", bus.lo, 32'h0);

    run_op("mult", 4'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div", 4'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(4'd4, 32'h1234, 32'h0);
    issue(4'd5, 32'h1234, 32'h0);
    run_op("divu by zero", 4'd3, 32'd7, 32'd0, 10, 32'h1234, 32'h1234);

    issue(4'd4, 32'hDEAD_BEEF, 32'h0);
    chk("mthi hi", bus.hi, 32'hDEAD_BEEF);
    chk("mthi busy", bus.busy, 1'b0);
    chk("mthi done", bus.done, 1'b0);
    @(negedge clk);
    chk("mthi done later", bus.done, 1'b0);

    // MTLO arriving while a MULT is in flight must be dropped.
    bus.start = 1'b1; bus.op = 4'd0; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.op = 4'd5; bus.a = 32'h5555;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(n);
    chk("mtlo while busy lo", bus.lo, 32'd12);
    chk("mtlo while busy hi", bus.hi, 32'd0);

    issue(4'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", bus.busy, 1'b0);
    chk("abort hi", bus.hi, 32'h0);
    chk("abort lo", bus.lo, 32'h0);
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    chk("abort no done", saw_done, 1'b0);

`ifdef MDU_MADD_EN
    issue(4'd5, 32'hFFFF_FFFF, 32'h0);
    issue(4'd4, 32'h0, 32'h0);
    run_op("maddu", 4'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    run_op("msub", 4'd8, 32'd1, 32'd2, 5, 32'd0, 32'hFFFF_FFFE);
`else
    issue(4'd4, 32'hAA, 32'h0);
    issue(4'd5, 32'hBB, 32'h0);
    issue(4'd6, 32'd1, 32'd1);
    chk("op6 busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("op6 hi", bus.hi, 32'hAA);
    chk("op6 lo", bus.lo, 32'hBB);
    chk("op6 done", bus.done, 1'b0);
`endif

    run_op("div overflow", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    // Back-to-back: start lands in the done cycle.
    bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b busy", bus.busy, 1'b1);
    wait_idle(n);
    chk("b2b cycles", n, 5);
    chk("b2b lo", bus.lo, 32'd30);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 249) == 0);
      bus.start = ($urandom_range(0, 2) != 0);
      bus.op    = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 9));
      bus.a     = rnd_val();
      bus.b     = rnd_val();
    end
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It sits in the EX stage beside the ALU. It accepts one operation per `start` pulse and holds `busy` for a fixed, operation-dependent latency. The hazard unit stalls later multiply/divide/HI/LO instructions on `start | busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for multiply-class operations (≥1).
- `DIV_CYCLES`, 10: busy cycles for divide-class operations (≥1).
- `clk` in 1: clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: op/a/b are valid this cycle.
- `op` in 4: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; other codes are no-ops.
- `a` in WIDTH: rs operand (dividend / multiplicand / MT source).
- `b` in WIDTH: rt operand (divisor / multiplier).
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse on the first cycle the new HI/LO is visible.
- `hi` out WIDTH: HI register, read directly for MFHI.
- `lo` out WIDTH: LO register, read directly for MFLO.

## Operation
- States are IDLE and BUSY, with a down-counter `cnt` of width clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- `start` is accepted only in IDLE. `start` while BUSY is ignored: no state change and no operand capture.
- IDLE, accepted MULT-class or DIV-class op:
  - latch op, a, b;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- IDLE, MTHI/MTLO: `hi`/`lo` <= `a` on that same edge. Busy never asserts and `done` never pulses.
- BUSY: decrement `cnt` each cycle. When `cnt` reaches 1, on that edge:
  - write HI/LO;
  - go to IDLE;
  - set `done` for the next cycle.
- The result is computed from the latched operands. The internal implementation (iterative or a single combinational product/quotient) is free, but the externally visible latency is exact.
- MULT: {hi,lo} = signed a × signed b (2·WIDTH product). MULTU: unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend. DIVU: unsigned.
  - Signed overflow (a = 0x8000_0000, b = 0xFFFF_FFFF at WIDTH=32): lo = 0x8000_0000, hi = 0.
  - Divide by zero, DIV or DIVU: latency is still DIV_CYCLES, `done` still pulses, HI/LO stay unchanged.
- MADD/MADDU/MSUB/MSUBU: {hi,lo} = {hi,lo} ± product, modulo 2^(2·WIDTH). They use MULT_CYCLES latency, and the {hi,lo} accumulated is the value at completion. They exist only under the macro below.
- Reset (any state, including mid-operation): state IDLE, cnt 0, busy 0, done 0, hi 0, lo 0. An in-flight operation is discarded.

## Timing
- `start` accepted at edge E0. `busy` = 1 from E0 until edge E0+N, where N is MULT_CYCLES or DIV_CYCLES, so busy is high for exactly N cycles.
- HI/LO change at edge E0+N. `done` = 1 for the single cycle after E0+N.
- `busy` is registered. `start` → `busy` has one edge of latency, so stall logic must use `start | busy`.
- Back-to-back: a `start` in the cycle `done` is high is accepted.
- `hi`/`lo` outputs come straight from registers with zero read latency. MFHI/MFLO in the same cycle as MTHI sees the old value.
- `done` and the HI/LO write never coincide with a reset cycle; reset wins.

## Configuration
- `MDU_MADD_EN` defined: op codes 6–9 execute as multiply-accumulate as described above.
- `MDU_MADD_EN` undefined: op codes 6–9 are no-ops, identical to undefined codes. No accumulate adder is synthesised.

## Test plan
- Reset, then MULT a=0xFFFF_FFFE (−2), b=3 → busy high 5 cycles, done pulses; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. MULTU with the same operands → hi=0x0000_0002, lo=0xFFFF_FFFA.
- DIV a=0xFFFF_FFF9 (−7), b=2 → busy 10 cycles; lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU a=7, b=0 with hi=lo=0x1234 beforehand → busy 10 cycles, done pulses, hi/lo stay 0x1234.
- MTHI a=0xDEAD_BEEF in IDLE → hi=0xDEAD_BEEF next cycle, busy stays 0, no done. Then MULT with a second `start` of MTLO while busy → MTLO ignored; lo holds the product.
- Reset asserted on the 3rd busy cycle of DIVU 100/7 → next cycle busy=0, hi=lo=0, and no done afterwards.
- With `MDU_MADD_EN`: hi=0, lo=0xFFFF_FFFF, then MADDU a=1, b=1 → hi=1, lo=0. MSUB a=1, b=2 → hi=0, lo=0xFFFF_FFFE. Without the macro, op 6 leaves hi/lo unchanged and busy stays 0.
- DIV with a=0x8000_0000, b=0xFFFF_FFFF → lo=0x8000_0000, hi=0. A start in the done cycle is accepted, and busy re-asserts at the next edge.
